serial_paralelo_alineado: RTL and testbench

Serial-to-parallel receiver directly downstream of the 10-bit serializer. It accepts one bit per enabled `clk` cycle, MSB (bit 9) first. It recovers 10-bit word boundaries by hunting for 8b/10b K28.5 commas, confirms lock after a run of aligned commas, and emits each recovered word with a one-cycle valid strobe. It feeds the 8b/10b decoder stage.

---
 rtl/serial_paralelo_alineado.sv | 142 ++++++++++++++
 tb/tb_serial_paralelo_alineado.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_alineado.sv
// 10-bit serial-to-parallel receiver, MSB first, that aligns word boundaries on K28.5 commas.
// It declares lock after a run of aligned commas and drops lock after repeated misaligned commas.
module serial_paralelo_alineado #(
  parameter int unsigned COMMAS_BLOQUEO  = 3,
  parameter int unsigned ERRORES_PERDIDA = 2,
  parameter logic [9:0]  COMA_NEG        = 10'h0FA,
  parameter logic [9:0]  COMA_POS        = 10'h305
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       entrada,
  output logic [9:0] salida,
  output logic       valida,
  output logic       coma,
  output logic       alineado
);

  typedef enum logic [1:0] {
    BUSCANDO    = 2'd0,
    VERIFICANDO = 2'd1,
    ALINEADO    = 2'd2
  } estado_t;

  localparam logic [2:0] CB = 3'(COMMAS_BLOQUEO);
  localparam logic [2:0] EP = 3'(ERRORES_PERDIDA);

  estado_t    estado_q, estado_d;
  logic [9:0] sr_q, sr_d;
  logic [9:0] salida_q, salida_d;
  logic [3:0] fase_q, fase_d;
  logic [2:0] cuenta_q, cuenta_d;
  logic [2:0] errores_q, errores_d;
  logic       valida_q, valida_d;
  logic       coma_q, coma_d;
  logic       alineado_q, alineado_d;

  logic       es_coma;
  logic       palabra_llena;
  logic [3:0] fase_inc;
  logic [2:0] cuenta_inc;
  logic [2:0] errores_inc;
  logic       captura;
  logic       rearranque;

  assign es_coma       = (sr_q == COMA_NEG) || (sr_q == COMA_POS);
  assign palabra_llena = (fase_q == 4'd10);
  assign fase_inc      = (fase_q >= 4'd10) ? 4'd10 : fase_q + 4'd1;
  assign cuenta_inc    = (cuenta_q == 3'd7) ? 3'd7 : cuenta_q + 3'd1;
  assign errores_inc   = (errores_q == 3'd7) ? 3'd7 : errores_q + 3'd1;

  always_comb begin
    sr_d       = sr_q;
    fase_d     = fase_q;
    cuenta_d   = cuenta_q;
    errores_d  = errores_q;
    estado_d   = estado_q;
    salida_d   = salida_q;
    valida_d   = 1'b0;
    coma_d     = 1'b0;
    captura    = 1'b0;
    rearranque = 1'b0;

    if (enb) begin
      sr_d   = {sr_q[8:0], entrada};
      fase_d = fase_inc;
      case (estado_q)
        BUSCANDO: begin
          if (es_coma) rearranque = 1'b1;
        end
        VERIFICANDO: begin
          if (palabra_llena) begin
            captura = 1'b1;
            if (es_coma) begin
              cuenta_d = cuenta_inc;
              if (cuenta_inc >= CB) estado_d = ALINEADO;
            end
          end else if (es_coma) begin
            rearranque = 1'b1;
          end
        end
        ALINEADO: begin
          if (palabra_llena) begin
            captura = 1'b1;
            if (es_coma) errores_d = '0;
          end else if (es_coma) begin
            if (errores_inc >= EP) rearranque = 1'b1;
            else                   errores_d  = errores_inc;
          end
        end
        default: estado_d = BUSCANDO;
      endcase

      // Re-phasing on a comma: that comma becomes the new word boundary.
      if (rearranque) begin
        captura   = 1'b1;
        cuenta_d  = 3'd1;
        errores_d = '0;
        estado_d  = (CB == 3'd1) ? ALINEADO : VERIFICANDO;
      end

      if (captura) begin
        salida_d = sr_q;
        valida_d = 1'b1;
        coma_d   = es_coma;
        fase_d   = 4'd1;
      end
    end

    alineado_d = (estado_d == ALINEADO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q   <= BUSCANDO;
      sr_q       <= '0;
      salida_q   <= '0;
      fase_q     <= '0;
      cuenta_q   <= '0;
      errores_q  <= '0;
      valida_q   <= 1'b0;
      coma_q     <= 1'b0;
      alineado_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      sr_q       <= sr_d;
      salida_q   <= salida_d;
      fase_q     <= fase_d;
      cuenta_q   <= cuenta_d;
      errores_q  <= errores_d;
      valida_q   <= valida_d;
      coma_q     <= coma_d;
      alineado_q <= alineado_d;
    end
  end

  assign salida   = salida_q;
  assign valida   = valida_q;
  assign coma     = coma_q;
  assign alineado = alineado_q;

endmodule

// File: tb/tb_serial_paralelo_alineado.sv
// Scoreboard bench: random and directed serial streams drive two receivers (default and single-comma lock).
// A bit-position reference model predicts every captured word and the lock flag.
module tb_serial_paralelo_alineado;

  localparam logic [9:0] NEG = 10'h0FA;
  localparam logic [9:0] POS = 10'h305;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic       entrada = 1'b0;
  logic [9:0] salida0, salida1;
  logic       valida0, valida1, coma0, coma1, alineado0, alineado1;

  always #5 clk = ~clk;

  serial_paralelo_alineado dut0 (
    .clk(clk), .rst(rst), .enb(enb), .entrada(entrada),
    .salida(salida0), .valida(valida0), .coma(coma0), .alineado(alineado0)
  );

  serial_paralelo_alineado #(.COMMAS_BLOQUEO(1), .ERRORES_PERDIDA(1)) dut1 (
    .clk(clk), .rst(rst), .enb(enb), .entrada(entrada),
    .salida(salida1), .valida(valida1), .coma(coma1), .alineado(alineado1)
  );

  typedef struct {
    int         edge_n;
    logic [9:0] word;
    logic       c;
    logic       a;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  // Reference model: word starts are tracked as positions in the accepted bit stream.
  int         cb_of [2] = '{3, 1};
  int         ep_of [2] = '{2, 1};
  int         m_mode [2];   // 0 hunting, 1 verifying, 2 locked
  int         m_good [2];
  int         m_bad  [2];
  int         m_start[2];
  int         nbits;
  logic [9:0] win;
  logic       exp_alin[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_good[i] = 0; m_bad[i] = 0; m_start[i] = 0; exp_alin[i] = 1'b0;
    end
    nbits = 0;
    win   = '0;
  endfunction

  function automatic void model_step(input logic b, input int e);
    logic isc;
    logic aligned, cap, restart;
    exp_t it;
    isc = (win == NEG) || (win == POS);
    for (int i = 0; i < 2; i++) begin
      aligned = (m_mode[i] != 0) && (nbits - m_start[i] == 10);
      cap = 1'b0; restart = 1'b0;
      if (m_mode[i] == 0) begin
        if (isc) restart = 1'b1;
      end else if (aligned) begin
        cap = 1'b1;
        if (isc && m_mode[i] == 1) begin
          m_good[i]++;
          if (m_good[i] >= cb_of[i]) m_mode[i] = 2;
        end else if (isc) begin
          m_bad[i] = 0;
        end
      end else if (isc) begin
        if (m_mode[i] == 1) restart = 1'b1;
        else begin
          m_bad[i]++;
          if (m_bad[i] >= ep_of[i]) restart = 1'b1;
        end
      end
      if (restart) begin
        cap = 1'b1; m_good[i] = 1; m_bad[i] = 0;
        m_mode[i] = (cb_of[i] == 1) ? 2 : 1;
      end
      if (cap) begin
        m_start[i] = nbits;
        it.edge_n = e; it.word = win; it.c = isc; it.a = (m_mode[i] == 2);
        if (i == 0) q0.push_back(it); else q1.push_back(it);
      end
      exp_alin[i] = (m_mode[i] == 2);
    end
    win = {win[8:0], b};
    nbits++;
  endfunction

  function automatic logic q_empty(input int i);
    return (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
  endfunction

  function automatic exp_t q_front(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_pop(input int i);
    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  task automatic check_inst(input int i, input logic v, input logic [9:0] s,
                            input logic c, input logic a);
    exp_t e;
    while (!q_empty(i) && q_front(i).edge_n < edge_cnt) begin
      chk($sformatf("missed_valida%0d", i), 32'd0, 32'd1);
      q_pop(i);
    end
    if (v) begin
      if (q_empty(i) || q_front(i).edge_n != edge_cnt) begin
        chk($sformatf("unexpected_valida%0d", i), 32'd1, 32'd0);
      end else begin
        e = q_front(i);
        q_pop(i);
        chk($sformatf("salida%0d", i), 32'(s), 32'(e.word));
        chk($sformatf("coma%0d", i), 32'(c), 32'(e.c));
        chk($sformatf("alineado_at_capture%0d", i), 32'(a), 32'(e.a));
      end
    end
    chk($sformatf("alineado%0d", i), 32'(a), 32'(exp_alin[i]));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      check_inst(0, valida0, salida0, coma0, alineado0);
      check_inst(1, valida1, salida1, coma1, alineado1);
    end
  end

  task automatic drive(input logic b, input logic en);
    @(negedge clk);
    entrada = b;
    enb     = en;
    if (rst && en) model_step(b, edge_cnt + 1);
  endtask

  task automatic send_word(input logic [9:0] w, input logic gated);
    for (int k = 9; k >= 0; k--) begin
      drive(w[k], 1'b1);
      if (gated) drive(1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic send_word_rand(input logic [9:0] w);
    for (int k = 9; k >= 0; k--) begin
      while ($urandom_range(0, 4) == 0) drive(1'($urandom_range(0, 1)), 1'b0);
      drive(w[k], 1'b1);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_alineado0"}, 32'(alineado0), 32'd0);
    chk({tag, "_valida0"},   32'(valida0),   32'd0);
    chk({tag, "_coma0"},     32'(coma0),     32'd0);
    chk({tag, "_salida0"},   32'(salida0),   32'd0);
    chk({tag, "_alineado1"}, 32'(alineado1), 32'd0);
  endtask

  // Reset lands between edges; a capture the driver predicted for the next edge is discarded.
  task automatic apply_reset(input int hold);
    @(negedge clk);
    #2;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    #1;
    check_zero_outputs("async_reset");
    repeat (hold) drive(1'($urandom_range(0, 1)), 1'b1);
    @(negedge clk);
    rst = 1'b0;
    enb = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout edge=%0d", edge_cnt);
    $fatal(1);
  end

  initial begin
    logic [9:0] w;
    logic       b, lastb;
    int         run, r;

    model_reset();
    #1 rst = 1'b0;
    #2 check_zero_outputs("power_on_reset");
    repeat (5) drive(1'($urandom_range(0, 1)), 1'b1);
    @(negedge clk);
    enb = 1'b0;
    rst = 1'b1;

    // Acquisition
    repeat (3) drive(1'($urandom_range(0, 1)), 1'b1);
    send_word(10'h0FA, 1'b0);
    send_word(10'h0A5, 1'b0);
    send_word(10'h305, 1'b0);
    send_word(10'h0FA, 1'b0);
    send_word(10'h1C3, 1'b0);
    chk("acq_locked0", 32'(alineado0), 32'd1);
    chk("acq_locked1", 32'(alineado1), 32'd1);

    // Loss of lock after a one-bit slip
    send_word(10'h0FA, 1'b0);
    drive(1'($urandom_range(0, 1)), 1'b1);
    send_word(10'h0FA, 1'b0);
    send_word(10'h0FA, 1'b0);
    chk("slip_first_keeps_lock", 32'(alineado0), 32'd1);
    send_word(10'h1C3, 1'b0);
    chk("slip_second_drops_lock", 32'(alineado0), 32'd0);
    send_word(10'h0FA, 1'b0);
    send_word(10'h0FA, 1'b0);
    send_word(10'h1C3, 1'b0);
    chk("relock_after_slip", 32'(alineado0), 32'd1);

    // Reset mid-word after lock
    repeat (4) drive(1'($urandom_range(0, 1)), 1'b1);
    chk("pre_reset_locked", 32'(alineado0), 32'd1);
    apply_reset(3);
    send_word(10'h0FA, 1'b0);
    send_word(10'h0FA, 1'b0);
    send_word(10'h1C3, 1'b0);
    chk("relock_partial", 32'(alineado0), 32'd0);
    send_word(10'h0FA, 1'b0);
    send_word(10'h1C3, 1'b0);
    chk("relock_done", 32'(alineado0), 32'd1);

    // Gated enable acquisition
    apply_reset(2);
    repeat (3) begin
      drive(1'($urandom_range(0, 1)), 1'b1);
      drive(1'($urandom_range(0, 1)), 1'b0);
    end
    send_word(10'h0FA, 1'b1);
    send_word(10'h0A5, 1'b1);
    send_word(10'h305, 1'b1);
    send_word(10'h0FA, 1'b1);
    send_word(10'h1C3, 1'b1);
    chk("gated_acq_locked0", 32'(alineado0), 32'd1);

    // Randomized mix of commas, data, slips and enable gaps
    apply_reset(2);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      w = NEG;
      else if (r < 5) w = POS;
      else            w = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(1, 3);
        repeat (r) drive(1'($urandom_range(0, 1)), 1'b1);
      end
      send_word_rand(w);
    end

    // Stream with no run of five equal bits can never contain a comma
    apply_reset(2);
    run = 0;
    lastb = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      b = 1'($urandom_range(0, 1));
      if (run == 4 && b == lastb) b = ~lastb;
      if (k == 0 || b != lastb) run = 1;
      else run++;
      lastb = b;
      drive(b, 1'b1);
    end
    chk("nocomma_alineado0", 32'(alineado0), 32'd0);
    chk("nocomma_valida0", 32'(valida0), 32'd0);

    repeat (3) drive(1'b0, 1'b0);
    chk("final_queue0_empty", 32'(q0.size()), 32'd0);
    chk("final_queue1_empty", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
